ii_gen: RTL and testbench

Streaming integral-image generator for one detection window. It accepts a raster-order pixel stream and emits two lockstep output streams: the integral image (ii) and the squared integral image (sii). Each output carries a 2-bit end-of-transfer tag, so it plugs directly into the ii/sii inputs of the stddev and window-sum path. It sits between the image scaler/window extractor and the stddev and classifier-stage consumers.

---
 rtl/ii_gen_pkg.sv | 36 +++
 rtl/ii_gen_if.sv | 50 +++++
 rtl/ii_row_buffer.sv | 40 ++++
 rtl/ii_gen.sv | 177 +++++++++++++++++
 tb/tb_ii_gen.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ii_gen_pkg.sv
// ---------------------------------------------------------------------------
// ii_gen_pkg
//
// Shared definitions for the integral-image datapath (ii_gen, stddev,
// window_sum):
//   - EOT_ROW / EOT_FRAME : bit positions inside the 2-bit end-of-transfer tag
//   - W_EOT               : width of the end-of-transfer tag
//   - min_w_ii()          : minimum bit width that holds a full-window sum
//   - min_w_sii()         : minimum bit width that holds a full-window sum of
//                           squared pixels
// ---------------------------------------------------------------------------
package ii_gen_pkg;

  localparam int W_EOT     = 2;
  localparam int EOT_ROW   = 0;  // last column of a row
  localparam int EOT_FRAME = 1;  // last pixel of the window

  // Smallest width that can represent ww*wh*(2**wpix-1) without wrapping.
  function automatic int min_w_ii(input int ww, input int wh, input int wpix);
    longint max_pix;
    longint max_sum;
    max_pix = (longint'(1) << wpix) - 1;
    max_sum = longint'(ww) * longint'(wh) * max_pix;
    return $clog2(max_sum + 1);
  endfunction

  // Smallest width that can represent ww*wh*(2**wpix-1)**2 without wrapping.
  function automatic int min_w_sii(input int ww, input int wh, input int wpix);
    longint max_pix;
    longint max_sum;
    max_pix = (longint'(1) << wpix) - 1;
    max_sum = longint'(ww) * longint'(wh) * max_pix * max_pix;
    return $clog2(max_sum + 1);
  endfunction

endpackage

// File: rtl/ii_gen_if.sv
// ---------------------------------------------------------------------------
// ii_gen_if
//
// Stream bundle around ii_gen: one pixel input channel and two lockstep
// output channels (ii and sii), each with valid/ready flow control.
//
//   pix_valid/pix_ready/pix_data : raster-order pixel input
//   ii_valid/ii_ready/ii_data    : integral-image output
//   ii_eot                       : bit EOT_ROW = end of row, EOT_FRAME = end of window
//   sii_valid/sii_ready/sii_data : squared integral-image output
//   sii_eot                      : same encoding as ii_eot
//
// Modports:
//   master : the environment around the generator (drives pixels, consumes
//            ii/sii)
//   slave  : the generator itself (ii_gen)
// ---------------------------------------------------------------------------
interface ii_gen_if
  import ii_gen_pkg::*;
#(
  parameter int W_PIX = 8,
  parameter int W_II  = 18,
  parameter int W_SII = 26
);

  logic             pix_valid;
  logic             pix_ready;
  logic [W_PIX-1:0] pix_data;

  logic             ii_valid;
  logic             ii_ready;
  logic [W_II-1:0]  ii_data;
  logic [W_EOT-1:0] ii_eot;

  logic             sii_valid;
  logic             sii_ready;
  logic [W_SII-1:0] sii_data;
  logic [W_EOT-1:0] sii_eot;

  modport master (
    output pix_valid, pix_data, ii_ready, sii_ready,
    input  pix_ready, ii_valid, ii_data, ii_eot, sii_valid, sii_data, sii_eot
  );

  modport slave (
    input  pix_valid, pix_data, ii_ready, sii_ready,
    output pix_ready, ii_valid, ii_data, ii_eot, sii_valid, sii_data, sii_eot
  );

endinterface

// File: rtl/ii_row_buffer.sv
// ---------------------------------------------------------------------------
// ii_row_buffer
//
// DEPTH x W register array holding the previous row's integral values.
// Read is combinational, write is synchronous, so a read and a write to the
// same entry in one cycle returns the old contents. No reset: every entry is
// written during row 0 of a window before it is read, and row 0 ignores the
// read data.
//
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module ii_row_buffer #(
  parameter int DEPTH = 24,
  parameter int W     = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ii_gen.sv
// ---------------------------------------------------------------------------
// ii_gen
//
// Streaming integral-image generator for one WINDOW_WIDTH x WINDOW_HEIGHT
// detection window. Every accepted pixel p at (col,row) produces
//   ii(col,row)  = sum of p      over all (x<=col, y<=row)
//   sii(col,row) = sum of p*p    over all (x<=col, y<=row)
// on two output channels that are loaded together but drain independently.
//
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   io  : ii_gen_if.slave (pixel input, ii and sii outputs with eot tags)
// ---------------------------------------------------------------------------
module ii_gen
  import ii_gen_pkg::*;
#(
  parameter int W_PIX         = 8,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24,
  parameter int W_II          = 18,
  parameter int W_SII         = 26
) (
  input logic     clk,
  input logic     rst,
  ii_gen_if.slave io
);

  localparam int CW = $clog2(WINDOW_WIDTH);
  localparam int RW = $clog2(WINDOW_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WINDOW_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(WINDOW_HEIGHT - 1);

  // Reject output widths that could wrap for a full window of max pixels.
  if (W_II < min_w_ii(WINDOW_WIDTH, WINDOW_HEIGHT, W_PIX)) begin : g_bad_w_ii
    $error("ii_gen: W_II too small for the window and pixel width");
  end
  if (W_SII < min_w_sii(WINDOW_WIDTH, WINDOW_HEIGHT, W_PIX)) begin : g_bad_w_sii
    $error("ii_gen: W_SII too small for the window and pixel width");
  end

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [W_II-1:0]    row_sum;
  logic [W_SII-1:0]   row_sq;

  logic               accept;
  logic               last_col;
  logic               last_row;
  logic [2*W_PIX-1:0] pix_ext;
  logic [2*W_PIX-1:0] pix_sq;
  logic [W_II-1:0]    row_sum_new;
  logic [W_SII-1:0]   row_sq_new;
  logic [W_II-1:0]    buf_ii_rd;
  logic [W_SII-1:0]   buf_sii_rd;
  logic [W_II-1:0]    prev_ii;
  logic [W_SII-1:0]   prev_sii;
  logic [W_II-1:0]    ii_new;
  logic [W_SII-1:0]   sii_new;
  logic [W_EOT-1:0]   eot_new;

  logic               ii_valid_q;
  logic [W_II-1:0]    ii_data_q;
  logic [W_EOT-1:0]   ii_eot_q;
  logic               sii_valid_q;
  logic [W_SII-1:0]   sii_data_q;
  logic [W_EOT-1:0]   sii_eot_q;

  // A new pixel can only be taken when both output registers will be free
  // after this edge; the two channels share one pixel so they must not skew.
  assign io.pix_ready = (!ii_valid_q || io.ii_ready) && (!sii_valid_q || io.sii_ready);
  assign accept       = io.pix_valid && io.pix_ready;

  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  always_comb begin
    pix_ext = {{W_PIX{1'b0}}, io.pix_data};
    pix_sq  = pix_ext * pix_ext;

    // Column 0 starts a fresh row sum; stale row_sum from the previous row is dropped.
    row_sum_new = ((col == '0) ? '0 : row_sum) + W_II'(io.pix_data);
    row_sq_new  = ((col == '0) ? '0 : row_sq)  + W_SII'(pix_sq);

    // Row 0 ignores the buffer, which isolates each window from the last one.
    prev_ii  = (row == '0) ? '0 : buf_ii_rd;
    prev_sii = (row == '0) ? '0 : buf_sii_rd;

    ii_new  = prev_ii  + row_sum_new;
    sii_new = prev_sii + row_sq_new;

    eot_new            = '0;
    eot_new[EOT_ROW]   = last_col;
    eot_new[EOT_FRAME] = last_col && last_row;
  end

  ii_row_buffer #(
    .DEPTH (WINDOW_WIDTH),
    .W     (W_II),
    .AW    (CW)
  ) u_buf_ii (
    .clk   (clk),
    .we    (accept),
    .waddr (col),
    .wdata (ii_new),
    .raddr (col),
    .rdata (buf_ii_rd)
  );

  ii_row_buffer #(
    .DEPTH (WINDOW_WIDTH),
    .W     (W_SII),
    .AW    (CW)
  ) u_buf_sii (
    .clk   (clk),
    .we    (accept),
    .waddr (col),
    .wdata (sii_new),
    .raddr (col),
    .rdata (buf_sii_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      row_sum <= '0;
      row_sq  <= '0;
    end else if (accept) begin
      row_sum <= row_sum_new;
      row_sq  <= row_sq_new;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // A new accept overrides a same-cycle handshake so the fresh word is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ii_valid_q <= 1'b0;
      ii_data_q  <= '0;
      ii_eot_q   <= '0;
    end else if (accept) begin
      ii_valid_q <= 1'b1;
      ii_data_q  <= ii_new;
      ii_eot_q   <= eot_new;
    end else if (io.ii_ready) begin
      ii_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sii_valid_q <= 1'b0;
      sii_data_q  <= '0;
      sii_eot_q   <= '0;
    end else if (accept) begin
      sii_valid_q <= 1'b1;
      sii_data_q  <= sii_new;
      sii_eot_q   <= eot_new;
    end else if (io.sii_ready) begin
      sii_valid_q <= 1'b0;
    end
  end

  assign io.ii_valid  = ii_valid_q;
  assign io.ii_data   = ii_data_q;
  assign io.ii_eot    = ii_eot_q;
  assign io.sii_valid = sii_valid_q;
  assign io.sii_data  = sii_data_q;
  assign io.sii_eot   = sii_eot_q;

endmodule

// File: tb/tb_ii_gen.sv
// ---------------------------------------------------------------------------
// tb_ii_gen
//
// Self-checking bench for ii_gen. A reference model (2-D inclusion-exclusion
// integral image) predicts every ii/sii word and its eot tag; directed
// windows add hand-computed spot values.
// ---------------------------------------------------------------------------
module tb_ii_gen;

  localparam int W_PIX = 8;
  localparam int WW    = 24;
  localparam int WH    = 24;
  localparam int W_II  = 18;
  localparam int W_SII = 26;
  localparam int NPIX  = WW * WH;

  localparam int MODE_ONES = 0;
  localparam int MODE_MAX  = 1;
  localparam int MODE_RAMP = 2;
  localparam int MODE_TWOS = 3;
  localparam int MODE_RAND = 4;

  typedef struct {
    int     x;
    int     y;
    longint data;
    int     eot;
  } exp_t;

  logic clk;
  logic rst;

  ii_gen_if #(.W_PIX(W_PIX), .W_II(W_II), .W_SII(W_SII)) bus ();

  ii_gen #(
    .W_PIX         (W_PIX),
    .WINDOW_WIDTH  (WW),
    .WINDOW_HEIGHT (WH),
    .W_II          (W_II),
    .W_SII         (W_SII)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  exp_t   q_ii[$];
  exp_t   q_sii[$];
  longint ii_model  [WH][WW];
  longint sii_model [WH][WW];
  longint obs_ii    [WH][WW];
  longint obs_sii   [WH][WW];
  int     obs_ii_eot[WH][WW];
  int     mx = 0;
  int     my = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks_total++;
    if (observed == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int pixelFor(input int mode, input int x, input int y);
    case (mode)
      MODE_ONES: return 1;
      MODE_MAX:  return 255;
      MODE_RAMP: return (x + y) % 256;
      MODE_TWOS: return 2;
      default:   return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Inclusion-exclusion form of the integral image for the pixel at (mx,my).
  task automatic pushModel(input int p);
    longint l, u, lu, sl, su, slu;
    exp_t   e;
    int     eot;
    l   = (mx > 0) ? ii_model[my][mx-1] : 0;
    u   = (my > 0) ? ii_model[my-1][mx] : 0;
    lu  = (mx > 0 && my > 0) ? ii_model[my-1][mx-1] : 0;
    sl  = (mx > 0) ? sii_model[my][mx-1] : 0;
    su  = (my > 0) ? sii_model[my-1][mx] : 0;
    slu = (mx > 0 && my > 0) ? sii_model[my-1][mx-1] : 0;
    ii_model[my][mx]  = longint'(p) + l + u - lu;
    sii_model[my][mx] = longint'(p) * longint'(p) + sl + su - slu;
    eot = ((mx == WW-1) ? 1 : 0) | ((mx == WW-1 && my == WH-1) ? 2 : 0);
    e.x = mx; e.y = my; e.eot = eot;
    e.data = ii_model[my][mx];
    q_ii.push_back(e);
    e.data = sii_model[my][mx];
    q_sii.push_back(e);
    if (mx == WW-1) begin
      mx = 0;
      my = (my == WH-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  // Called #1 after the negedge with inputs already driven for the next edge.
  task automatic stepModel(input int p, output bit acc);
    bit exp_ready;
    exp_ready = (q_ii.size() == 0 || bus.ii_ready) && (q_sii.size() == 0 || bus.sii_ready);
    checkOutput("pix_ready", bus.pix_ready, exp_ready);
    checkOutput("ii_valid", bus.ii_valid, q_ii.size() != 0);
    checkOutput("sii_valid", bus.sii_valid, q_sii.size() != 0);
    if (q_ii.size() != 0) begin
      checkOutput($sformatf("ii_data(%0d,%0d)", q_ii[0].x, q_ii[0].y), bus.ii_data, q_ii[0].data);
      checkOutput($sformatf("ii_eot(%0d,%0d)", q_ii[0].x, q_ii[0].y), bus.ii_eot, q_ii[0].eot);
      if (bus.ii_ready) begin
        obs_ii[q_ii[0].y][q_ii[0].x]     = bus.ii_data;
        obs_ii_eot[q_ii[0].y][q_ii[0].x] = int'(bus.ii_eot);
        void'(q_ii.pop_front());
      end
    end
    if (q_sii.size() != 0) begin
      checkOutput($sformatf("sii_data(%0d,%0d)", q_sii[0].x, q_sii[0].y), bus.sii_data, q_sii[0].data);
      checkOutput($sformatf("sii_eot(%0d,%0d)", q_sii[0].x, q_sii[0].y), bus.sii_eot, q_sii[0].eot);
      if (bus.sii_ready) begin
        obs_sii[q_sii[0].y][q_sii[0].x] = bus.sii_data;
        void'(q_sii.pop_front());
      end
    end
    acc = bus.pix_valid && exp_ready;
    if (acc) pushModel(p);
  endtask

  // Offers pixels until n_pix have been accepted; stall_pct throttles
  // pix_valid and both readys independently.
  task automatic applyStimulus(input int mode, input int n_pix, input int stall_pct);
    int accepted = 0;
    int cycles   = 0;
    int p;
    bit acc;
    while (accepted < n_pix && cycles < 20000) begin
      @(negedge clk);
      p             = pixelFor(mode, mx, my);
      bus.pix_valid = ($urandom_range(0, 99) >= stall_pct);
      bus.pix_data  = p[W_PIX-1:0];
      bus.ii_ready  = ($urandom_range(0, 99) >= stall_pct);
      bus.sii_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      stepModel(p, acc);
      if (acc) accepted++;
      cycles++;
    end
    checkOutput("stim_accepted", accepted, n_pix);
  endtask

  task automatic drainOutputs();
    int cycles = 0;
    bit acc;
    while ((q_ii.size() != 0 || q_sii.size() != 0) && cycles < 16) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.ii_ready  = 1'b1;
      bus.sii_ready = 1'b1;
      #1;
      stepModel(0, acc);
      cycles++;
    end
    checkOutput("drain_left", q_ii.size() + q_sii.size(), 0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ii_valid"}, bus.ii_valid, 0);
    checkOutput({tag, "_sii_valid"}, bus.sii_valid, 0);
    checkOutput({tag, "_ii_data"}, bus.ii_data, 0);
    checkOutput({tag, "_sii_data"}, bus.sii_data, 0);
    checkOutput({tag, "_ii_eot"}, bus.ii_eot, 0);
    checkOutput({tag, "_sii_eot"}, bus.sii_eot, 0);
    checkOutput({tag, "_pix_ready"}, bus.pix_ready, 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.ii_ready  = 1'b0;
    bus.sii_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] all-ones window");
    applyStimulus(MODE_ONES, NPIX, 0);
    drainOutputs();
    checkOutput("ones_ii(0,0)", obs_ii[0][0], 1);
    checkOutput("ones_ii(5,3)", obs_ii[3][5], 24);
    checkOutput("ones_ii(23,23)", obs_ii[23][23], 576);
    checkOutput("ones_sii(23,23)", obs_sii[23][23], 576);
    checkOutput("ones_eot(23,0)", obs_ii_eot[0][23], 1);
    checkOutput("ones_eot(23,22)", obs_ii_eot[22][23], 1);
    checkOutput("ones_eot(10,5)", obs_ii_eot[5][10], 0);
    checkOutput("ones_eot(23,23)", obs_ii_eot[23][23], 3);

    $display("[TB] all-255 window");
    applyStimulus(MODE_MAX, NPIX, 0);
    drainOutputs();
    checkOutput("max_ii(0,0)", obs_ii[0][0], 255);
    checkOutput("max_sii(0,0)", obs_sii[0][0], 65025);
    checkOutput("max_ii(23,23)", obs_ii[23][23], 146880);
    checkOutput("max_sii(23,23)", obs_sii[23][23], 37454400);

    $display("[TB] ramp window");
    applyStimulus(MODE_RAMP, NPIX, 0);
    drainOutputs();
    checkOutput("ramp_ii(1,1)", obs_ii[1][1], 4);
    checkOutput("ramp_sii(1,1)", obs_sii[1][1], 6);
    checkOutput("ramp_ii(2,0)", obs_ii[0][2], 3);

    $display("[TB] random pixels with random stalls");
    applyStimulus(MODE_RAND, NPIX, 30);
    drainOutputs();

    $display("[TB] back-to-back ones then twos");
    applyStimulus(MODE_ONES, NPIX, 0);
    applyStimulus(MODE_TWOS, NPIX, 0);
    drainOutputs();
    checkOutput("twos_ii(0,0)", obs_ii[0][0], 2);
    checkOutput("twos_ii(23,23)", obs_ii[23][23], 1152);
    checkOutput("twos_sii(23,23)", obs_sii[23][23], 2304);

    $display("[TB] reset mid-window at pixel (5,3)");
    applyStimulus(MODE_ONES, 3 * WW + 6, 0);
    @(negedge clk);
    checkOutput("pre_rst_ii_valid", bus.ii_valid, 1);
    checkOutput("pre_rst_ii_data", bus.ii_data, 24);
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.ii_ready  = 1'b0;
    bus.sii_ready = 1'b0;
    @(negedge clk);
    checkResetState("midrst");
    rst = 1'b0;
    q_ii.delete();
    q_sii.delete();
    mx = 0;
    my = 0;
    applyStimulus(MODE_ONES, NPIX, 0);
    drainOutputs();
    checkOutput("post_rst_ii(0,0)", obs_ii[0][0], 1);
    checkOutput("post_rst_ii(23,23)", obs_ii[23][23], 576);
    checkOutput("post_rst_sii(23,23)", obs_sii[23][23], 576);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
